vc_injection_arbiter: RTL and testbench

// - Wormhole-aware arbiter: shares one node injection link among VC per-VC flit sources.
// - Sits between the per-VC traffic generators/queues and the router local input port.
// - Grants whole packets (head..tail) round-robin; tags each flit with its VC index.

---
 rtl/vc_injection_arbiter_if.sv | 30 +++
 rtl/vc_injection_arbiter.sv | 124 ++++++++++++
 tb/tb_vc_injection_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vc_injection_arbiter_if.sv
// Injection-link bundle: per-VC flit sources in, one tagged flit stream out.
// master = sources/router side, slave = arbiter side.
interface vc_injection_arbiter_if #(
  parameter int VC         = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  // Handshake: a flit moves on every cycle where valid and ready are both high.
  // The arbiter never lets valid_out depend on ready_out.
  logic [VC*DATA_WIDTH-1:0] req_data;
  logic [VC-1:0]            req_valid;
  logic [VC-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]    data_out;
  logic                     valid_out;
  logic                     ready_out;
  logic [$clog2(VC)-1:0]    vc_out;
  logic                     busy;
  logic                     err_proto;
  logic [VC*CNT_WIDTH-1:0]  pkt_count;

  modport master (
    output req_data, req_valid, ready_out,
    input  req_ready, data_out, valid_out, vc_out, busy, err_proto, pkt_count
  );

  modport slave (
    input  req_data, req_valid, ready_out,
    output req_ready, data_out, valid_out, vc_out, busy, err_proto, pkt_count
  );
endinterface

// File: rtl/vc_injection_arbiter.sv
// Wormhole injection arbiter: grants whole packets round-robin across VCs.
// Define VC_ARB_PKT_COUNT_EN to build the per-VC completed-packet counters.
module vc_injection_arbiter #(
  parameter int VC              = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int IDENTIFIER_BITS = 2,
  parameter int CNT_WIDTH       = 16
) (
  input logic                   clk,
  input logic                   rst,
  vc_injection_arbiter_if.slave bus
);
  localparam int VC_W = $clog2(VC);
  localparam logic [IDENTIFIER_BITS-1:0] FT_HEAD = IDENTIFIER_BITS'(1);
  localparam logic [IDENTIFIER_BITS-1:0] FT_BODY = IDENTIFIER_BITS'(2);
  localparam logic [IDENTIFIER_BITS-1:0] FT_TAIL = IDENTIFIER_BITS'(3);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t                     state;
  logic [VC_W-1:0]            lock_vc;
  logic [VC_W-1:0]            last_vc;
  logic                       err_q;

  logic [DATA_WIDTH-1:0]      flit  [VC];
  logic [IDENTIFIER_BITS-1:0] ftype [VC];
  logic                       grant_any;
  logic [VC_W-1:0]            sel_vc;
  logic [VC_W-1:0]            idx;
  logic                       err_set;
  logic                       xfer;

  always_comb begin
    for (int i = 0; i < VC; i++) begin
      flit[i]  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      ftype[i] = flit[i][DATA_WIDTH-1 -: IDENTIFIER_BITS];
    end
  end

  // IDLE scans heads starting just after last_vc; the VC_W-bit sum wraps naturally.
  always_comb begin
    grant_any = 1'b0;
    sel_vc    = lock_vc;
    err_set   = 1'b0;
    idx       = '0;
    if (state == S_IDLE) begin
      sel_vc = '0;
      for (int k = 1; k <= VC; k++) begin
        idx = last_vc + VC_W'(k);
        if (!grant_any && bus.req_valid[idx] && ftype[idx] == FT_HEAD) begin
          grant_any = 1'b1;
          sel_vc    = idx;
        end
      end
      for (int i = 0; i < VC; i++) begin
        if (bus.req_valid[i] && ftype[i] != FT_HEAD) err_set = 1'b1;
      end
    end else if (bus.req_valid[lock_vc]) begin
      if (ftype[lock_vc] == FT_BODY || ftype[lock_vc] == FT_TAIL) grant_any = 1'b1;
      else                                                        err_set   = 1'b1;
    end
  end

  // Outputs are forced quiet while rst is high so no flit moves in a reset cycle.
  assign xfer          = grant_any & bus.ready_out & ~rst;
  assign bus.valid_out = grant_any & ~rst;
  assign bus.data_out  = bus.valid_out ? flit[sel_vc] : '0;
  assign bus.vc_out    = bus.valid_out ? sel_vc : '0;
  assign bus.busy      = (state == S_LOCKED);
  assign bus.err_proto = err_q;

  always_comb begin
    bus.req_ready = '0;
    if (xfer) bus.req_ready[sel_vc] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      lock_vc <= '0;
      last_vc <= VC_W'(VC - 1);
      err_q   <= 1'b0;
    end else begin
      if (err_set) err_q <= 1'b1;
      if (xfer) begin
        case (state)
          S_IDLE: begin
            state   <= S_LOCKED;
            lock_vc <= sel_vc;
          end
          S_LOCKED: begin
            if (ftype[lock_vc] == FT_TAIL) begin
              state   <= S_IDLE;
              last_vc <= lock_vc;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef VC_ARB_PKT_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt [VC];
  logic                 tail_done;

  assign tail_done = xfer && (state == S_LOCKED) && (ftype[lock_vc] == FT_TAIL);

  // Saturating: a counter parked at all-ones stays there until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VC; i++) cnt[i] <= '0;
    end else if (tail_done && cnt[lock_vc] != '1) begin
      cnt[lock_vc] <= cnt[lock_vc] + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < VC; i++) bus.pkt_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
  end
`else
  assign bus.pkt_count = {VC*CNT_WIDTH{1'b0}};
`endif
endmodule

// File: tb/tb_vc_injection_arbiter.sv
// Bench for vc_injection_arbiter: directed phases then a randomized run, all
// compared against a packet-level reference model through scoreboard queues.
module tb_vc_injection_arbiter;
  localparam int VC = 4;
  localparam int DW = 32;
  localparam int IB = 2;
  localparam int CW = 16;
  localparam int VW = $clog2(VC);
  localparam logic [IB-1:0] HEAD = 2'b01;
  localparam logic [IB-1:0] BODY = 2'b10;
  localparam logic [IB-1:0] TAIL = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vc_injection_arbiter_if #(.VC(VC), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  vc_injection_arbiter #(
    .VC(VC), .DATA_WIDTH(DW), .IDENTIFIER_BITS(IB), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic          v;
    logic [VW-1:0] vc;
    logic [DW-1:0] d;
    logic [VC-1:0] rdy;
    logic          busy;
    logic          err;
    logic [VC*CW-1:0] cnt;
  } status_t;

  status_t          stat_q[$];
  logic [VW+DW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- sources ----------------
  int            left [VC];
  logic [DW-1:0] cur  [VC];
  logic [DW-1:0] drv  [VC];
  logic [VC-1:0] en = '0;
  logic [VC-1:0] acc = '0;
  logic [VC-1:0] in_valid = '0;
  logic          in_ready = 1'b0;
  logic          g_rst = 1'b1;
  logic          rogue3 = 1'b0;
  int len_lo = 2, len_hi = 5, gap_pct = 0, ready_mode = 1;

  function automatic logic [DW-1:0] mk(input logic [IB-1:0] t);
    logic [DW-1:0] f;
    f = $urandom;
    f[DW-1 -: IB] = t;
    return f;
  endfunction

  // ---------------- reference model (packet ownership view) ----------------
  bit m_init = 0;
  bit m_busy = 0;
  int m_owner = 0;
  int m_last = VC - 1;
  bit m_err = 0;
  int m_cnt [VC];

  task automatic model_step();
    status_t s;
    int win;
    bit err_now;
    logic [IB-1:0] t;
    win = -1;
    err_now = 0;
    if (!m_busy) begin
      for (int k = 1; k <= VC; k++) begin
        int v;
        v = (m_last + k) % VC;
        if (win < 0 && in_valid[v] && drv[v][DW-1 -: IB] == HEAD) win = v;
      end
      for (int v = 0; v < VC; v++)
        if (in_valid[v] && drv[v][DW-1 -: IB] != HEAD) err_now = 1;
    end else if (in_valid[m_owner]) begin
      t = drv[m_owner][DW-1 -: IB];
      if (t == BODY || t == TAIL) win = m_owner;
      else err_now = 1;
    end

    if (m_init) begin
      s.v = 1'b0; s.vc = '0; s.d = '0; s.rdy = '0;
      if (!rst && win >= 0) begin
        s.v  = 1'b1;
        s.vc = VW'(win);
        s.d  = drv[win];
        if (in_ready) s.rdy[win] = 1'b1;
      end
      s.busy = m_busy;
      s.err  = m_err;
`ifdef VC_ARB_PKT_COUNT_EN
      for (int v = 0; v < VC; v++) s.cnt[v*CW +: CW] = CW'(m_cnt[v]);
`else
      s.cnt = '0;
`endif
      stat_q.push_back(s);
    end

    if (rst) begin
      m_init = 1; m_busy = 0; m_owner = 0; m_last = VC - 1; m_err = 0;
      foreach (m_cnt[v]) m_cnt[v] = 0;
    end else begin
      if (err_now) m_err = 1;
      if (win >= 0 && in_ready) begin
        exp_q.push_back({VW'(win), drv[win]});
        if (!m_busy) begin
          m_busy = 1; m_owner = win;
        end else if (drv[win][DW-1 -: IB] == TAIL) begin
          m_busy = 0; m_last = m_owner;
          if (m_cnt[m_owner] < (1 << CW) - 1) m_cnt[m_owner]++;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(negedge clk);
    for (int v = 0; v < VC; v++) begin
      if (acc[v]) begin
        left[v]--;
        if (left[v] > 0) cur[v] = mk(left[v] == 1 ? TAIL : BODY);
      end
      if (rst) left[v] = 0;
    end
    rst = g_rst;
    for (int v = 0; v < VC; v++) begin
      if (en[v] && left[v] == 0) begin
        left[v] = $urandom_range(len_hi, len_lo);
        cur[v]  = mk(HEAD);
      end
      drv[v]      = cur[v];
      in_valid[v] = (left[v] > 0) && ($urandom_range(99, 0) >= gap_pct);
    end
    if (rogue3) begin
      drv[3] = mk(BODY);
      in_valid[3] = 1'b1;
    end
    in_ready = (ready_mode == 2) ? ($urandom_range(3, 0) != 0) : (ready_mode == 1);
    for (int v = 0; v < VC; v++) bus.req_data[v*DW +: DW] = drv[v];
    bus.req_valid = in_valid;
    bus.ready_out = in_ready;
    model_step();
    #2;
    acc = bus.req_ready & bus.req_valid;
  endtask

  task automatic drain();
    int n;
    bit pending;
    n = 0;
    en = '0;
    pending = 1;
    while (pending && n < 100) begin
      pending = m_busy;
      for (int v = 0; v < VC; v++) if (left[v] > 0) pending = 1;
      if (pending) begin step(); n++; end
    end
    check("drain_bound", 64'(n < 100), 64'd1);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    status_t s;
    logic [VW+DW-1:0] e;
    #2;
    if (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      check("valid_out", 64'(bus.valid_out), 64'(s.v));
      check("vc_out",    64'(bus.vc_out),    64'(s.vc));
      check("data_out",  64'(bus.data_out),  64'(s.d));
      check("req_ready", 64'(bus.req_ready), 64'(s.rdy));
      check("busy",      64'(bus.busy),      64'(s.busy));
      check("err_proto", 64'(bus.err_proto), 64'(s.err));
      check("pkt_count", 64'(bus.pkt_count), 64'(s.cnt));
    end
    if (bus.valid_out === 1'b1 && bus.ready_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer: got vc %0d flit %0h expected no transfer", bus.vc_out, bus.data_out);
      end else begin
        e = exp_q.pop_front();
        check("xfer", 64'({bus.vc_out, bus.data_out}), 64'(e));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int v = 0; v < VC; v++) begin
      left[v] = 0; cur[v] = '0; drv[v] = '0; m_cnt[v] = 0;
    end
    bus.req_data = '0;
    bus.req_valid = '0;
    bus.ready_out = 1'b0;

    g_rst = 1; repeat (2) step(); g_rst = 0;

    // single 3-flit packet on VC0
    len_lo = 3; len_hi = 3; en = 4'b0001; step(); en = '0;
    repeat (4) step();

    // all VCs with 2-flit packets from a fresh reset: 0,1,2,3,0...
    g_rst = 1; step(); g_rst = 0;
    len_lo = 2; len_hi = 2; en = 4'b1111;
    repeat (10) step();
    drain();

    // VC1/VC2 contend, ready_out held low for 5 cycles mid-packet
    len_lo = 4; len_hi = 4; en = 4'b0110;
    repeat (2) step();
    ready_mode = 0; repeat (5) step(); ready_mode = 1;
    drain();

    // VC3 streams body flits in IDLE; VC0 packet must still complete
    rogue3 = 1; repeat (3) step();
    len_lo = 3; len_hi = 3; en = 4'b0001; step(); en = '0;
    repeat (6) step();
    rogue3 = 0;
    drain();

    // reset in the middle of a VC2 packet, then VC0/VC2 heads together
    len_lo = 5; len_hi = 5; en = 4'b0100;
    repeat (2) step();
    g_rst = 1; step(); g_rst = 0;
    len_lo = 2; len_hi = 2; en = 4'b0101;
    repeat (8) step();
    drain();

    // randomized traffic with gaps, back-pressure and occasional reset
    len_lo = 2; len_hi = 5; gap_pct = 30; ready_mode = 2; en = 4'b1111;
    for (int c = 0; c < 3000; c++) begin
      g_rst = ($urandom_range(499, 0) == 0);
      step();
    end
    g_rst = 0; gap_pct = 0; ready_mode = 1;
    drain();
    repeat (2) step();

    @(negedge clk);
    #5;
    check("exp_q_empty",  64'(exp_q.size()),  64'd0);
    check("stat_q_empty", 64'(stat_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
